// File: rtl/stage_pkg.sv
// ---------------------------------------------------------------------------
// stage_pkg
// Shared definitions for the stage loader:
//   - brick-code constants EMPTY / SOLID
//   - loader FSM state enum
//   - stage_row(stage, row): built-in stage contents, 10 cells x 3 bits,
//     column 0 in the MSBs; undefined rows and stages read all-zero
//   - brick_popcount(): number of breakable cells (nonzero, not SOLID) in a row
// ---------------------------------------------------------------------------
package stage_pkg;

    localparam logic [2:0] EMPTY = 3'b000;
    localparam logic [2:0] SOLID = 3'b111;

    // Native geometry of the built-in stage table.
    localparam int PKG_COLS   = 10;
    localparam int PKG_CELL_W = 3;
    localparam int PKG_ROW_W  = PKG_COLS * PKG_CELL_W;

    // Upper bounds accepted by brick_popcount; callers zero-extend into these.
    localparam int MAX_COLS   = 32;
    localparam int MAX_CELL_W = 4;
    localparam int MAX_ROW_W  = MAX_COLS * MAX_CELL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Stage 0 is reserved, so it has no content of its own.
    function automatic logic [PKG_ROW_W-1:0] stage_row(input int unsigned stage,
                                                       input int unsigned row);
        logic [PKG_ROW_W-1:0] bits;
        bits = '0;
        case (stage)
            1: case (row)
                0: bits = 30'b001_011_101_001_101_001_101_001_000_000;
                1: bits = 30'b010_010_010_010_010_010_010_010_010_010;
                2: bits = 30'b000_100_000_100_000_100_000_100_000_100;
                3: bits = 30'b111_001_000_000_000_000_000_000_001_111;
                default: bits = '0;
            endcase
            2: case (row)
                0: bits = 30'b111_011_101_001_111_001_101_001_000_000;
                1: bits = 30'b110_110_111_110_110_110_110_111_110_110;
                2: bits = 30'b001_000_001_000_001_000_001_000_001_000;
                3: bits = 30'b111_111_111_111_111_111_111_111_111_111;
                4: bits = 30'b011_011_011_011_011_000_000_000_000_000;
                default: bits = '0;
            endcase
            3: case (row)
                0: bits = 30'b100_100_100_100_100_100_100_100_100_100;
                1: bits = 30'b000_000_000_000_111_111_000_000_000_000;
                5: bits = 30'b101_000_000_000_000_000_000_000_000_101;
                default: bits = '0;
            endcase
            default: bits = '0;
        endcase
        return bits;
    endfunction

    // Counts breakable cells among the lowest `cols` cells of `data`.
    // Cell order does not matter for a count, so cells are walked from the LSB.
    function automatic int unsigned brick_popcount(input logic [MAX_ROW_W-1:0]  data,
                                                   input int unsigned           cols,
                                                   input int unsigned           cell_w,
                                                   input logic [MAX_CELL_W-1:0] solid);
        logic [MAX_CELL_W-1:0] mask;
        logic [MAX_CELL_W-1:0] code;
        int unsigned           total;
        total = 0;
        mask  = MAX_CELL_W'((32'd1 << cell_w) - 32'd1);
        for (int unsigned c = 0; c < MAX_COLS; c++) begin
            code = MAX_CELL_W'(data >> (c * cell_w)) & mask;
            if ((c < cols) && (code != MAX_CELL_W'(EMPTY)) && (code != (solid & mask))) begin
                total++;
            end
        end
        return total;
    endfunction

endpackage

// File: rtl/stage_table.sv
// ---------------------------------------------------------------------------
// stage_table
// Stage-content lookup with a registered output (1-cycle latency).
// Ports:
//   clock, reset  - clock, asynchronous active-high reset
//   load          - capture the row addressed by {stage,row} on this edge
//   stage, row    - lookup address
//   data          - registered row contents, column 0 in the MSBs
// ---------------------------------------------------------------------------
module stage_table #(
    parameter int COLS   = 10,
    parameter int CELL_W = 3,
    parameter int ROWS   = 32,
    parameter int STAGES = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load,
    input  logic [$clog2(STAGES)-1:0]    stage,
    input  logic [$clog2(ROWS)-1:0]      row,
    output logic [COLS*CELL_W-1:0]       data
);
    import stage_pkg::*;

    logic [PKG_ROW_W-1:0]   raw;
    logic [COLS*CELL_W-1:0] lookup;

    always_comb begin
        raw = stage_row(32'(stage), 32'(row));
    end

    // Re-pack the native 10x3 table into this instance's geometry; columns
    // beyond the table's width read as empty.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            if (gi < PKG_COLS) begin : g_def
                assign lookup[(COLS-1-gi)*CELL_W +: CELL_W] =
                    CELL_W'(raw[(PKG_COLS-1-gi)*PKG_CELL_W +: PKG_CELL_W]);
            end else begin : g_pad
                assign lookup[(COLS-1-gi)*CELL_W +: CELL_W] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= lookup;
        end
    end

endmodule

// File: rtl/stage_loader.sv
// ---------------------------------------------------------------------------
// stage_loader
// Copies one stage from the built-in table into a brick-map RAM, one row per
// valid/ready handshake, and counts the breakable bricks it wrote.
// Ports:
//   clock, reset   - clock, asynchronous active-high reset
//   start, stage   - load request (sampled in IDLE) and stage to load
//   wr_ready       - RAM accepts the presented row
//   wr_valid, wr_addr, wr_data - row write towards the RAM
//   busy           - load in progress (FETCH or WRITE)
//   done, error    - one-cycle pulses: load finished / invalid stage requested
//   brick_count    - breakable bricks of the last completed load
// ---------------------------------------------------------------------------
module stage_loader #(
    parameter int                COLS   = 10,
    parameter int                CELL_W = 3,
    parameter int                ROWS   = 32,
    parameter int                STAGES = 4,
    parameter logic [CELL_W-1:0] SOLID  = 3'b111
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [$clog2(STAGES)-1:0]          stage,
    input  logic                               wr_ready,
    output logic                               wr_valid,
    output logic [$clog2(ROWS)-1:0]            wr_addr,
    output logic [COLS*CELL_W-1:0]             wr_data,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [$clog2(ROWS*COLS+1)-1:0]     brick_count
);
    import stage_pkg::*;

    localparam int SW    = $clog2(STAGES);
    localparam int RW    = $clog2(ROWS);
    // Wide enough for every cell of every row to be breakable: never wraps.
    localparam int CNT_W = $clog2(ROWS*COLS+1);

    state_t              state_reg, state_next;
    logic [SW-1:0]       stage_reg;
    logic [RW-1:0]       row_reg;
    logic [CNT_W-1:0]    acc_reg;
    logic [CNT_W-1:0]    brick_count_reg;
    logic                done_reg;
    logic                error_reg;
    logic [COLS*CELL_W-1:0] table_data;

    logic                stage_ok;
    logic                last_row;
    logic [CNT_W-1:0]    row_bricks;

    assign stage_ok   = (stage != '0) && (32'(stage) < 32'(STAGES));
    assign last_row   = (row_reg == RW'(ROWS-1));
    assign row_bricks = CNT_W'(brick_popcount(MAX_ROW_W'(wr_data), 32'(COLS), 32'(CELL_W),
                                              MAX_CELL_W'(SOLID)));

    stage_table #(
        .COLS   (COLS),
        .CELL_W (CELL_W),
        .ROWS   (ROWS),
        .STAGES (STAGES)
    ) u_table (
        .clock (clock),
        .reset (reset),
        .load  (state_reg == FETCH),
        .stage (stage_reg),
        .row   (row_reg),
        .data  (table_data)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && stage_ok) state_next = FETCH;
            FETCH:   state_next = WRITE;
            WRITE:   if (wr_ready) state_next = last_row ? FINISH : FETCH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy     = (state_reg == FETCH) || (state_reg == WRITE);
        wr_valid = (state_reg == WRITE);
    end

    // Datapath: latched stage, row pointer, accumulator and result pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_reg       <= '0;
            row_reg         <= '0;
            acc_reg         <= '0;
            brick_count_reg <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (stage_ok) begin
                            stage_reg <= stage;
                            row_reg   <= '0;
                            acc_reg   <= '0;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        acc_reg <= acc_reg + row_bricks;
                        if (!last_row) begin
                            row_reg <= row_reg + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    brick_count_reg <= acc_reg;
                    done_reg        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // wr_data stays put through a stall because the table only reloads in FETCH.
    assign wr_addr     = row_reg;
    assign wr_data     = table_data;
    assign done        = done_reg;
    assign error       = error_reg;
    assign brick_count = brick_count_reg;

endmodule

// File: tb/tb_stage_loader.sv
// ---------------------------------------------------------------------------
// tb_stage_loader
// Directed bench for stage_loader with a row-level reference model.
// ---------------------------------------------------------------------------
module tb_stage_loader;

    localparam int COLS   = 10;
    localparam int CELL_W = 3;
    localparam int ROWS   = 32;
    localparam int STAGES = 4;
    localparam int RW     = $clog2(ROWS);
    localparam int SW     = $clog2(STAGES);
    localparam int CW     = $clog2(ROWS*COLS+1);

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [SW-1:0]          stage = '0;
    logic                   wr_ready = 1'b1;
    logic                   wr_valid;
    logic [RW-1:0]          wr_addr;
    logic [COLS*CELL_W-1:0] wr_data;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [CW-1:0]          brick_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          active      = 1'b0;
    int          model_stage = 0;
    int          model_row   = 0;
    int          model_acc   = 0;
    int          fin_cnt     = 0;
    int          load_writes = 0;
    int          stall_cnt   = 0;
    logic [29:0] first_data  = '0;

    // Backpressure control
    int stall_row  = -1;
    int stall_left = 0;

    stage_loader #(
        .COLS   (COLS),
        .CELL_W (CELL_W),
        .ROWS   (ROWS),
        .STAGES (STAGES),
        .SOLID  (3'b111)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stage       (stage),
        .wr_ready    (wr_ready),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .brick_count (brick_count)
    );

    initial forever #5 clock = ~clock;

    // Expected stage contents
    function automatic logic [29:0] ref_row(input int s, input int r);
        logic [29:0] v;
        v = '0;
        if (s == 1) begin
            if (r == 0) v = 30'b001_011_101_001_101_001_101_001_000_000;
            if (r == 1) v = 30'b010_010_010_010_010_010_010_010_010_010;
            if (r == 2) v = 30'b000_100_000_100_000_100_000_100_000_100;
            if (r == 3) v = 30'b111_001_000_000_000_000_000_000_001_111;
        end else if (s == 2) begin
            if (r == 0) v = 30'b111_011_101_001_111_001_101_001_000_000;
            if (r == 1) v = 30'b110_110_111_110_110_110_110_111_110_110;
            if (r == 2) v = 30'b001_000_001_000_001_000_001_000_001_000;
            if (r == 3) v = 30'b111_111_111_111_111_111_111_111_111_111;
            if (r == 4) v = 30'b011_011_011_011_011_000_000_000_000_000;
        end else if (s == 3) begin
            if (r == 0) v = 30'b100_100_100_100_100_100_100_100_100_100;
            if (r == 1) v = 30'b000_000_000_000_111_111_000_000_000_000;
            if (r == 5) v = 30'b101_000_000_000_000_000_000_000_000_101;
        end
        return v;
    endfunction

    function automatic int ref_bricks(input logic [29:0] d);
        int          k;
        logic [2:0]  c;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            c = d[i*3 +: 3];
            if (c != 3'b000 && c != 3'b111) k++;
        end
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one start request; a valid one arms the model at the sampling edge.
    task automatic do_start(input logic [SW-1:0] s);
        @(posedge clock);
        #1;
        start = 1'b1;
        stage = s;
        @(posedge clock);
        if (s != '0) begin
            active      = 1'b1;
            model_stage = int'(s);
            model_row   = 0;
            model_acc   = 0;
            fin_cnt     = 0;
            load_writes = 0;
        end
        #1;
        start = 1'b0;
        $display("start stage=%0d", s);
    endtask

    // Returns the cycle (counted from the start cycle as 0) where done shows.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("done_seen", done, 1'b1);
        $display("load done at cycle %0d, brick_count=%0d", n, brick_count);
    endtask

    // Ready driver: stalls the configured row for stall_left WRITE cycles.
    initial forever begin
        @(posedge clock);
        #1;
        if (wr_valid && int'(wr_addr) == stall_row && stall_left > 0) begin
            wr_ready   = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            wr_ready = 1'b1;
        end
    end

    // Compare process: checks every cycle against the row-level model.
    initial begin : cmp
        bit exp_done;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("busy", busy, active && model_row < ROWS);
                exp_done = 1'b0;
                if (active && model_row == ROWS) begin
                    exp_done = (fin_cnt == 1);
                    fin_cnt++;
                end
                check("done", done, exp_done);
                if (done && active) begin
                    check("brick_count", brick_count, model_acc);
                    check("rows_written", load_writes, ROWS);
                    active = 1'b0;
                end
                if (wr_valid) begin
                    if (!active || model_row >= ROWS) begin
                        check("spurious_write", wr_valid, 1'b0);
                    end else begin
                        check("wr_addr", wr_addr, model_row);
                        check("wr_data", wr_data, ref_row(model_stage, model_row));
                        if (model_row == 0) first_data = wr_data;
                        if (wr_ready) begin
                            $display("write row=%0d data=%h", wr_addr, wr_data);
                            model_acc += ref_bricks(ref_row(model_stage, model_row));
                            model_row++;
                            load_writes++;
                        end else begin
                            stall_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int n;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_brick_count", brick_count, 0);
        reset = 1'b0;

        // Stage 1, no backpressure: cycle-exact done and pinned row 0 / count
        do_start(2'd1);
        wait_done(n);
        check("s1_done_cycle", n, 66);
        check("s1_row0", first_data, 30'b001_011_101_001_101_001_101_001_000_000);
        check("s1_count", brick_count, 25);

        // Stage 2 with 5 stall cycles on row 3
        stall_cnt  = 0;
        stall_row  = 3;
        stall_left = 5;
        do_start(2'd2);
        wait_done(n);
        check("s2_done_cycle", n, 71);
        check("s2_row0", first_data, 30'b111_011_101_001_111_001_101_001_000_000);
        check("s2_count", brick_count, 24);
        check("s2_stall_cycles", stall_cnt, 5);
        stall_row = -1;

        // Invalid stage 0
        @(posedge clock);
        #1;
        start = 1'b1;
        stage = 2'd0;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("err_pulse", error, 1'b1);
        check("err_busy", busy, 1'b0);
        @(posedge clock);
        #1;
        check("err_clear", error, 1'b0);
        check("err_busy2", busy, 1'b0);
        check("err_count_kept", brick_count, 24);
        $display("start stage=0 rejected, error pulse seen");

        // Start with another stage while busy is ignored
        do_start(2'd1);
        repeat (6) @(posedge clock);
        #1;
        check("restart_busy", busy, 1'b1);
        start = 1'b1;
        stage = 2'd2;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ignored_count", brick_count, 25);

        // Reset at row 10 of a stage 3 load, then reload
        do_start(2'd3);
        n = 0;
        while (!(wr_valid && wr_addr == RW'(10)) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reached_row10", wr_addr, 10);
        active = 1'b0;
        reset  = 1'b1;
        #1;
        check("abort_wr_valid", wr_valid, 1'b0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_error", error, 1'b0);
        check("abort_brick_count", brick_count, 0);
        $display("reset asserted mid-load at row 10");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("idle_after_abort", busy, 1'b0);
        do_start(2'd3);
        wait_done(n);
        check("s3_done_cycle", n, 66);
        check("s3_row0", first_data, 30'b100_100_100_100_100_100_100_100_100_100);
        check("s3_count", brick_count, 12);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
